// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and FSM state type for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef enum logic {INIT, RUN} rf_state_e;

  // Never narrower than one bit, so NREGS=2 still gets a usable address.
  function automatic int unsigned rf_aw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// Per-read-port select: forced zero, same-cycle write bypass, or the stored array value.
module regfile_fwd_mux import regfile_pkg::*; #(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = rf_aw(NREGS)
) (
  input  logic                rst,
  input  logic                ready_i,
  input  logic [AW-1:0]       rd_addr_i,
  input  logic [XLEN-1:0]     arr_data_i,
  input  logic [NWR-1:0]      wr_ok_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0]     rd_data_o
);

  always_comb begin
    rd_data_o = arr_data_i;
    // Ascending scan so the highest-numbered matching port wins.
    if (BYPASS != 0) begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wr_ok_i[k] && (wr_addr_i[k*AW +: AW] == rd_addr_i)) begin
          rd_data_o = wr_data_i[k*XLEN +: XLEN];
        end
      end
    end
    if (rst || !ready_i || (rd_addr_i == '0) || (32'(rd_addr_i) >= NREGS)) begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/regfile_mport.sv
// Multi-port flop register file with a post-reset sequential clear and optional write bypass.
module regfile_mport import regfile_pkg::*; #(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  output logic                ready_o
);

  rf_state_e       state_q;
  logic [AW-1:0]   clr_idx_q;
  logic            ready_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [NWR-1:0]  wr_ok;

  assign ready_o = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      clr_idx_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          clr_idx_q <= clr_idx_q + AW'(1);
          if (clr_idx_q == AW'(NREGS - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: ready_q <= 1'b1;
        default: state_q <= INIT;
      endcase
    end
  end

  // Address-qualified enables; state/reset gating is applied at the array and read mux.
  always_comb begin
    wr_ok = '0;
    for (int unsigned k = 0; k < NWR; k++) begin
      wr_ok[k] = wr_en_i[k] && (wr_addr_i[k*AW +: AW] != '0) &&
                 (32'(wr_addr_i[k*AW +: AW]) < NREGS);
    end
  end

  // No reset on the array; later ports overwrite earlier ones on address collisions.
  always_ff @(posedge clk) begin
    regs_q[0] <= '0;
    if (!rst) begin
      if (state_q == INIT) begin
        regs_q[clr_idx_q] <= '0;
      end else begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (wr_ok[k]) begin
            regs_q[wr_addr_i[k*AW +: AW]] <= wr_data_i[k*XLEN +: XLEN];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] arr;

    assign ra  = rd_addr_i[p*AW +: AW];
    assign arr = (32'(ra) < NREGS) ? regs_q[ra] : '0;

    regfile_fwd_mux #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NWR    (NWR),
      .BYPASS (BYPASS),
      .AW     (AW)
    ) u_fwd_mux (
      .rst        (rst),
      .ready_i    (ready_q),
      .rd_addr_i  (ra),
      .arr_data_i (arr),
      .wr_ok_i    (wr_ok),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .rd_data_o  (rd_data_o[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mport.sv
// Directed bench for regfile_mport: default, no-bypass and 24-entry/3-read-port instances.
module tb_regfile_mport;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [2*AW-1:0]     rd_addr;
  logic [3*AW-1:0]     rd_addr_s;
  logic [2*XLEN-1:0]   rd_data, rd_data_nb;
  logic [3*XLEN-1:0]   rd_data_s;
  logic [1:0]          wr_en;
  logic [2*AW-1:0]     wr_addr;
  logic [2*XLEN-1:0]   wr_data;
  logic                ready, ready_nb, ready_s;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_mport u_dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .ready_o   (ready)
  );

  regfile_mport #(.BYPASS(0)) u_nb (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data_nb),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .ready_o   (ready_nb)
  );

  regfile_mport #(.NREGS(24), .NRD(3)) u_small (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (rd_data_s),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .ready_o   (ready_s)
  );

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] exp0, exp1, nb0;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        5'd5, 5'd5,
                32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd5, 5'd0,
                32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{2'b11, 5'd7,  5'd7,  32'h11111111, 32'h22222222, 5'd7, 5'd7,
                32'h22222222, 32'h22222222, 32'h0};
    vecs[3] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd7, 5'd5,
                32'h22222222, 32'hDEADBEEF, 32'h22222222};
    vecs[4] = '{2'b11, 5'd0,  5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0,
                32'h0,        32'h0,        32'h0};
    vecs[5] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd0, 5'd0,
                32'h0,        32'h0,        32'h0};
    vecs[6] = '{2'b11, 5'd1,  5'd31, 32'hCAFEF00D, 32'h12345678, 5'd1, 5'd31,
                32'hCAFEF00D, 32'h12345678, 32'h0};
    vecs[7] = '{2'b10, 5'd1,  5'd2,  32'h99999999, 32'h0BADF00D, 5'd1, 5'd2,
                32'hCAFEF00D, 32'h0BADF00D, 32'hCAFEF00D};
    vecs[8] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd31, 5'd2,
                32'h12345678, 32'h0BADF00D, 32'h12345678};
    vecs[9] = '{2'b11, 5'd5,  5'd6,  32'h5555AAAA, 32'h66666666, 5'd6, 5'd5,
                32'h66666666, 32'h5555AAAA, 32'h0};

    // Reset held: writes and bypass must not leak to the read ports.
    rd_addr   = {5'd0, 5'd5};
    rd_addr_s = {5'd0, 5'd5, 5'd5};
    set_wr(2'b01, 5'd5, 5'd0, 32'h00001234, 32'h0);
    tick();
    tick();
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.ready_s", 32'(ready_s), 32'd0);
    check("rst.rd0", rd_data[31:0], 32'h0);
    check("rst.rd1", rd_data[63:32], 32'h0);

    // Clear sequence: writes during the first 20 INIT edges must be dropped.
    rst = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      if (e <= 20) set_wr(2'b01, 5'd3, 5'd0, 32'hAAAA5555, 32'h0);
      else         set_wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      check($sformatf("init.ready@%0d", e), 32'(ready), (e == 31) ? 32'd1 : 32'd0);
      check($sformatf("init.ready_nb@%0d", e), 32'(ready_nb), (e == 31) ? 32'd1 : 32'd0);
      check($sformatf("init.ready_s@%0d", e), 32'(ready_s), (e >= 23) ? 32'd1 : 32'd0);
    end
    set_wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    for (int i = 1; i <= 31; i++) begin
      rd_addr = {5'(i), 5'(i)};
      #1;
      check($sformatf("init.x%0d", i), rd_data[31:0], 32'h0);
    end

    // Table-driven run-mode vectors; bypass expectations sampled before the edge.
    for (int i = 0; i < 10; i++) begin
      set_wr(vecs[i].en, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1);
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("vec%0d.rd0", i), rd_data[31:0], vecs[i].exp0);
      check($sformatf("vec%0d.rd1", i), rd_data[63:32], vecs[i].exp1);
      check($sformatf("vec%0d.nb0", i), rd_data_nb[31:0], vecs[i].nb0);
      tick();
    end

    // 24-entry instance: x30 is out of range, lower registers unaffected.
    set_wr(2'b01, 5'd30, 5'd0, 32'h77777777, 32'h0);
    rd_addr_s = {5'd5, 5'd23, 5'd30};
    #1;
    check("small.x30_byp", rd_data_s[31:0], 32'h0);
    check("small.x23", rd_data_s[63:32], 32'h0);
    check("small.x5", rd_data_s[95:64], 32'h5555AAAA);
    tick();
    set_wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    rd_addr_s = {5'd0, 5'd7, 5'd30};
    #1;
    check("small.x30_after", rd_data_s[31:0], 32'h0);
    check("small.x7", rd_data_s[63:32], 32'h22222222);
    check("small.x0", rd_data_s[95:64], 32'h0);

    // Fill x1..x31, then pulse reset and verify the re-clear.
    for (int i = 1; i <= 31; i += 2) begin
      set_wr(2'b11, 5'(i), 5'(i + 1), 32'(i) * 32'h01010101, 32'(i + 1) * 32'h01010101);
      tick();
    end
    set_wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    for (int i = 1; i <= 31; i++) begin
      rd_addr = {5'(i), 5'(i)};
      #1;
      check($sformatf("fill.x%0d", i), rd_data[63:32], 32'(i) * 32'h01010101);
      check($sformatf("fill_nb.x%0d", i), rd_data_nb[31:0], 32'(i) * 32'h01010101);
    end
    rst = 1'b1;
    set_wr(2'b01, 5'd9, 5'd0, 32'h0F0F0F0F, 32'h0);
    rd_addr = {5'd9, 5'd9};
    #1;
    check("rstpulse.rd_byp", rd_data[31:0], 32'h0);
    tick();
    check("rstpulse.ready", 32'(ready), 32'd0);
    rst = 1'b0;
    set_wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    for (int e = 1; e <= 31; e++) begin
      tick();
      check($sformatf("reclr.ready@%0d", e), 32'(ready), (e == 31) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i <= 31; i++) begin
      rd_addr = {5'(i), 5'(i)};
      #1;
      check($sformatf("reclr.x%0d", i), rd_data[31:0], 32'h0);
      check($sformatf("reclr_nb.x%0d", i), rd_data_nb[63:32], 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
